// File: rtl/lcd_pkg.sv
// Shared LCD command codes, image/window geometry and host FSM encoding,
// used by the host sequencer and the LCD controller.
package lcd_pkg;

  typedef enum logic [2:0] {
    CMD_LOAD     = 3'd0,
    CMD_ZOOM_IN  = 3'd1,
    CMD_ZOOM_FIT = 3'd2,
    CMD_RIGHT    = 3'd3,
    CMD_LEFT     = 3'd4,
    CMD_UP       = 3'd5,
    CMD_DOWN     = 3'd6,
    CMD_ILLEGAL  = 3'd7
  } lcd_cmd_e;

  typedef enum logic [1:0] {
    HOST_IDLE     = 2'd0,
    HOST_ISSUE    = 2'd1,
    HOST_LOAD     = 2'd2,
    HOST_WAIT_OUT = 2'd3
  } host_state_e;

  localparam int IMG_SIZE  = 108;
  localparam int OUT_BEATS = 16;
  localparam int WDT_MAX   = 255;

  // Beat counter increment that parks at its maximum instead of wrapping.
  function automatic logic [4:0] sat_inc5(input logic [4:0] v);
    return (v == 5'd31) ? v : v + 5'd1;
  endfunction

endpackage

// File: rtl/lcd_host_wdt.sv
// Watchdog for the controller's busy phase: counts busy cycles while armed
// and flags expiry once the count reaches MAX.
module lcd_host_wdt #(
  parameter int MAX = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic busy,
  output logic expired
);
  localparam logic [7:0] LIMIT = 8'(MAX);

  logic [7:0] count_r;

  // Busy-cycle count, restarted by clear and parked at the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= 8'd0;
    end else if (clear) begin
      count_r <= 8'd0;
    end else if (busy && (count_r != LIMIT)) begin
      count_r <= count_r + 8'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == LIMIT);

endmodule

// File: rtl/lcd_host_seq.sv
// Host-side sequencer: issues queued LCD commands over cmd/cmd_valid/busy,
// streams the image ROM on LOAD and forwards the returned display window.
module lcd_host_seq
  import lcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] req_cmd,
  input  logic       req_valid,
  output logic       req_ready,
  output logic       img_rd,
  output logic [6:0] img_addr,
  input  logic [7:0] img_data,
  output logic [2:0] cmd,
  output logic       cmd_valid,
  input  logic       busy,
  output logic [7:0] datain,
  input  logic [7:0] dataout,
  input  logic       output_valid,
  output logic [7:0] res_data,
  output logic       res_valid,
  output logic       res_last,
  output logic       done,
  output logic       err_beats,
  output logic       err_timeout,
  output logic       err_cmd
);
  localparam logic [1:0] S_IDLE     = HOST_IDLE;
  localparam logic [1:0] S_ISSUE    = HOST_ISSUE;
  localparam logic [1:0] S_LOAD     = HOST_LOAD;
  localparam logic [1:0] S_WAIT_OUT = HOST_WAIT_OUT;
  localparam logic [6:0] LAST_ADDR  = 7'(IMG_SIZE - 1);
  localparam logic [4:0] FULL_BEATS = 5'(OUT_BEATS);

  logic [1:0] state_r, state_next_s;
  logic [2:0] cmd_r;
  logic       cmd_valid_r, req_ready_r, rd_valid_r;
  logic [6:0] addr_r;
  logic [7:0] datain_hold_r, res_data_r;
  logic [4:0] beats_r, beats_next_s;
  logic       res_valid_r, res_last_r, done_r;
  logic       err_beats_r, err_timeout_r, err_cmd_r;
  logic       in_xfer_s, take_req_s, legal_req_s, accept_s, load_go_s;
  logic       beat_s, finish_s, timeout_s, wdt_expired_s;

  assign in_xfer_s    = (state_r == S_LOAD) || (state_r == S_WAIT_OUT);
  assign take_req_s   = (state_r == S_IDLE) && req_ready_r && req_valid;
  assign legal_req_s  = take_req_s && (req_cmd != CMD_ILLEGAL);
  assign accept_s     = (state_r == S_ISSUE) && cmd_valid_r && !busy;
  assign load_go_s    = accept_s && (cmd_r == CMD_LOAD);
  assign beat_s       = in_xfer_s && output_valid;
  assign beats_next_s = beat_s ? sat_inc5(beats_r) : beats_r;
  assign timeout_s    = in_xfer_s && wdt_expired_s;
  assign finish_s     = (state_r == S_WAIT_OUT) && !busy && !wdt_expired_s;

  lcd_host_wdt #(.MAX(WDT_MAX)) u_wdt (
    .clk     (clk),
    .reset   (reset),
    .clear   (!in_xfer_s),
    .busy    (busy),
    .expired (wdt_expired_s)
  );

  // Next-state logic; the watchdog overrides normal progress in LOAD/WAIT_OUT.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (legal_req_s) state_next_s = S_ISSUE;
        else             state_next_s = S_IDLE;
      end
      S_ISSUE: begin
        if (load_go_s)     state_next_s = S_LOAD;
        else if (accept_s) state_next_s = S_WAIT_OUT;
        else               state_next_s = S_ISSUE;
      end
      S_LOAD: begin
        if (timeout_s)                state_next_s = S_IDLE;
        else if (addr_r == LAST_ADDR) state_next_s = S_WAIT_OUT;
        else                          state_next_s = S_LOAD;
      end
      S_WAIT_OUT: begin
        if (timeout_s || finish_s) state_next_s = S_IDLE;
        else                       state_next_s = S_WAIT_OUT;
      end
      default: state_next_s = S_IDLE;
    endcase
  end

  // FSM, command handshake and image-stream registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= S_IDLE;
      req_ready_r   <= 1'b0;
      cmd_r         <= 3'd0;
      cmd_valid_r   <= 1'b0;
      addr_r        <= 7'd0;
      rd_valid_r    <= 1'b0;
      datain_hold_r <= 8'd0;
    end else begin
      state_r     <= state_next_s;
      req_ready_r <= (state_next_s == S_IDLE);
      cmd_r       <= legal_req_s ? req_cmd : cmd_r;
      if (legal_req_s)   cmd_valid_r <= 1'b1;
      else if (accept_s) cmd_valid_r <= 1'b0;
      else               cmd_valid_r <= cmd_valid_r;
      addr_r        <= (state_next_s == S_LOAD) ? addr_r + 7'd1 : 7'd0;
      rd_valid_r    <= img_rd;
      datain_hold_r <= datain;
    end
  end

  // Result forwarding, beat counting and error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      beats_r       <= 5'd0;
      res_data_r    <= 8'd0;
      res_valid_r   <= 1'b0;
      res_last_r    <= 1'b0;
      done_r        <= 1'b0;
      err_beats_r   <= 1'b0;
      err_timeout_r <= 1'b0;
      err_cmd_r     <= 1'b0;
    end else begin
      beats_r       <= (state_next_s == S_IDLE) ? 5'd0 : beats_next_s;
      res_data_r    <= beat_s ? dataout : res_data_r;
      res_valid_r   <= beat_s;
      res_last_r    <= beat_s && (beats_next_s == FULL_BEATS);
      done_r        <= finish_s;
      err_beats_r   <= err_beats_r | (finish_s && (beats_next_s != FULL_BEATS));
      err_timeout_r <= err_timeout_r | timeout_s;
      err_cmd_r     <= take_req_s && (req_cmd == CMD_ILLEGAL);
    end
  end

  // The ROM read for address 0 must go out in the acceptance cycle itself.
  assign img_rd      = load_go_s || (state_r == S_LOAD);
  assign img_addr    = addr_r;
  assign datain      = rd_valid_r ? img_data : datain_hold_r;
  assign req_ready   = req_ready_r;
  assign cmd         = cmd_r;
  assign cmd_valid   = cmd_valid_r;
  assign res_data    = res_data_r;
  assign res_valid   = res_valid_r;
  assign res_last    = res_last_r;
  assign done        = done_r;
  assign err_beats   = err_beats_r;
  assign err_timeout = err_timeout_r;
  assign err_cmd     = err_cmd_r;

endmodule

// File: tb/tb_lcd_host_seq.sv
// Directed bench for lcd_host_seq with an inline image ROM and LCD controller model.
module tb_lcd_host_seq;
  import lcd_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] req_cmd;
  logic       req_valid, req_ready, img_rd, cmd_valid, busy, output_valid;
  logic [6:0] img_addr;
  logic [7:0] img_data, datain, dataout, res_data;
  logic [2:0] cmd;
  logic       res_valid, res_last, done, err_beats, err_timeout, err_cmd;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int errc_cnt = 0;
  logic [7:0] got_q[$];
  logic       last_q[$];
  logic [7:0] mem [0:IMG_SIZE-1];

  always #5 clk = ~clk;

  lcd_host_seq dut (
    .clk(clk), .reset(reset), .req_cmd(req_cmd), .req_valid(req_valid),
    .req_ready(req_ready), .img_rd(img_rd), .img_addr(img_addr), .img_data(img_data),
    .cmd(cmd), .cmd_valid(cmd_valid), .busy(busy), .datain(datain),
    .dataout(dataout), .output_valid(output_valid), .res_data(res_data),
    .res_valid(res_valid), .res_last(res_last), .done(done), .err_beats(err_beats),
    .err_timeout(err_timeout), .err_cmd(err_cmd)
  );

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ctrl_bits();
    return {13'd0, req_ready, img_rd, img_addr, cmd, cmd_valid, done, err_beats,
            err_timeout, err_cmd, res_valid, res_last};
  endfunction

  // Byte the controller model returns on beat i of a command.
  function automatic logic [7:0] beat_byte(input logic [2:0] code, input int i);
    if (code == CMD_LOAD) return mem[13 + 3 * (i % 4) + 24 * (i / 4)];
    else return 8'((int'(code) * 17 + i * 3 + 5) & 255);
  endfunction

  // Result-stream monitor, sampled well away from the clock edges.
  always @(negedge clk) begin
    #2;
    if (res_valid) begin
      got_q.push_back(res_data);
      last_q.push_back(res_last);
    end
    if (done) done_cnt++;
    if (err_cmd) errc_cnt++;
  end

  task automatic run_cmd(input logic [2:0] code, input int pre_busy, input int nbeats,
                         input int busy_len, input int rst_at, input logic exp_done);
    int k, t, b0, t_end;
    int hold_err, addr_err, lag_err, data_err, last_err, fit_err, store_err;
    logic aborted, prev_beat;
    logic [7:0] rom_next;
    logic [7:0] exp_q[$];
    got_q.delete();
    last_q.delete();
    done_cnt = 0;
    hold_err = 0; addr_err = 0; lag_err = 0;
    if (code == CMD_LOAD) for (int m = 0; m < IMG_SIZE; m++) mem[m] = 8'hFF;
    k = 0;
    do begin
      @(negedge clk);
      req_cmd = code;
      req_valid = 1'b1;
      #1;
      k++;
    end while (!req_ready && k < 20);
    check_value("req_accept", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    for (int w = 0; w < pre_busy; w++) begin
      busy = 1'b1;
      #1;
      if (cmd_valid !== 1'b1 || img_rd !== 1'b0) hold_err++;
      @(negedge clk);
    end
    busy = 1'b0;
    #1;
    check_value("cmd_valid_at_A", cmd_valid, 1);
    check_value("cmd_at_A", cmd, code);
    check_value("img_rd_at_A", img_rd, code == CMD_LOAD);
    if (code == CMD_LOAD) check_value("img_addr_at_A", img_addr, 0);
    rom_next = img_rd ? {1'b0, img_addr} : 8'hA5;
    b0 = (code == CMD_LOAD) ? 110 : 2;
    t_end = (busy_len > 0) ? busy_len + 1 : b0 + nbeats + 1;
    prev_beat = 1'b0;
    aborted = 1'b0;
    t = 1;
    while (t <= t_end + 1 && !aborted) begin
      @(negedge clk);
      if (rst_at > 0 && t == rst_at + 1) begin
        reset = 1'b0; busy = 1'b0; output_valid = 1'b0; dataout = 8'h00;
        #1;
        check_value("reset_ctrl_zero", ctrl_bits(), 0);
        check_value("reset_data_zero", {16'd0, datain, res_data}, 0);
        @(negedge clk);
        #1;
        check_value("ready_after_abort", req_ready, 1);
        aborted = 1'b1;
      end else begin
        img_data = rom_next;
        busy = (t < t_end);
        output_valid = (busy_len == 0) && (t >= b0) && (t < b0 + nbeats);
        dataout = 8'h00;
        if (output_valid) begin
          dataout = beat_byte(code, t - b0);
          exp_q.push_back(dataout);
        end
        reset = (t == rst_at);
        #1;
        if (t == 1) begin
          check_value("cmd_valid_drop", cmd_valid, 0);
          check_value("ready_low_active", req_ready, 0);
        end
        if (code == CMD_LOAD && t <= IMG_SIZE) mem[t - 1] = datain;
        if (code == CMD_LOAD && t < IMG_SIZE && (img_rd !== 1'b1 || img_addr !== 7'(t))) addr_err++;
        if (code == CMD_LOAD && t == IMG_SIZE && img_rd !== 1'b0) addr_err++;
        if (code == CMD_LOAD && t == 120) check_value("datain_hold", datain, 107);
        if (res_valid !== prev_beat) lag_err++;
        prev_beat = output_valid;
        rom_next = img_rd ? {1'b0, img_addr} : 8'hA5;
        if (busy_len > 0 && t == 240) check_value("wdt_not_early", err_timeout, 0);
        if (busy_len > 0 && t == 270) begin
          check_value("wdt_expired", err_timeout, 1);
          check_value("idle_after_wdt", req_ready, 1);
        end
        if (t == t_end) check_value("done_not_early", done, 0);
        if (t == t_end + 1) check_value("done_pulse", done, exp_done);
      end
      t++;
    end
    @(negedge clk);
    #3;
    check_value("done_count", done_cnt, exp_done);
    check_value("res_count", got_q.size(), aborted ? 0 : nbeats);
    check_value("cmd_valid_hold", hold_err, 0);
    check_value("res_lag", lag_err, 0);
    if (code == CMD_LOAD) check_value("img_addr_seq", addr_err, 0);
    if (!aborted) begin
      data_err = 0; last_err = 0; fit_err = 0; store_err = 0;
      for (int i = 0; i < got_q.size(); i++) begin
        if (i >= exp_q.size() || got_q[i] !== exp_q[i]) data_err++;
        if (last_q[i] !== (i == OUT_BEATS - 1)) last_err++;
        if (code == CMD_LOAD && got_q[i] !== 8'(13 + 3 * (i % 4) + 24 * (i / 4))) fit_err++;
      end
      if (code == CMD_LOAD) begin
        for (int m = 0; m < IMG_SIZE; m++) if (mem[m] !== 8'(m)) store_err++;
        check_value("img_store", store_err, 0);
        check_value("fit_window", fit_err, 0);
      end
      check_value("res_data", data_err, 0);
      check_value("res_last", last_err, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, observed no end required end");
    $fatal(1);
  end

  initial begin
    logic [2:0] seq [4];
    seq = '{CMD_LOAD, CMD_ZOOM_IN, CMD_RIGHT, CMD_DOWN};
    reset = 1'b1; req_cmd = 3'd0; req_valid = 1'b0; img_data = 8'd0;
    busy = 1'b0; dataout = 8'd0; output_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_value("reset_ctrl", ctrl_bits(), 0);
    check_value("reset_data", {16'd0, datain, res_data}, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_value("ready_during_release", req_ready, 0);
    @(negedge clk);
    #1;
    check_value("ready_after_release", req_ready, 1);

    run_cmd(CMD_LOAD, 0, 16, 0, -1, 1'b1);
    check_value("load_err_beats", err_beats, 0);
    check_value("load_err_timeout", err_timeout, 0);

    for (int c = 0; c < 4; c++) run_cmd(seq[c], 3, 16, 0, -1, 1'b1);
    check_value("b2b_err_beats", err_beats, 0);

    errc_cnt = 0;
    @(negedge clk);
    req_cmd = CMD_ILLEGAL;
    req_valid = 1'b1;
    #1;
    check_value("illegal_ready", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check_value("err_cmd_pulse", err_cmd, 1);
    check_value("illegal_no_cmd_valid", cmd_valid, 0);
    check_value("illegal_ready_after", req_ready, 1);
    @(negedge clk);
    #3;
    check_value("err_cmd_once", errc_cnt, 1);
    check_value("illegal_cmd_valid_later", cmd_valid, 0);

    run_cmd(CMD_ZOOM_FIT, 0, 15, 0, -1, 1'b1);
    check_value("short_err_beats", err_beats, 1);
    run_cmd(CMD_UP, 0, 16, 0, -1, 1'b1);
    check_value("err_beats_sticky", err_beats, 1);
    check_value("no_timeout_yet", err_timeout, 0);

    run_cmd(CMD_LEFT, 0, 0, 300, -1, 1'b0);
    check_value("timeout_sticky", err_timeout, 1);

    run_cmd(CMD_LOAD, 0, 16, 0, 50, 1'b0);
    run_cmd(CMD_LOAD, 0, 16, 0, -1, 1'b1);
    check_value("fresh_err_beats", err_beats, 0);
    check_value("fresh_err_timeout", err_timeout, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
